// File: rtl/replay_batch_scheduler_pkg.sv
// Shared types and constants for the replay-memory batch scheduler.
package replay_batch_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int unsigned LFSR_WIDTH = 23;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 23'h000001;
  // Right-shift Galois mask for x^23 + x^18 + 1 (maximal length)
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 23'h420000;

endpackage

// File: rtl/replay_batch_scheduler_lfsr.sv
// 23-bit Galois LFSR with enable; the full state is exposed as the random draw.
module lfsr_galois_23
  import replay_batch_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [LFSR_WIDTH-1:0] lfsr_state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_state <= LFSR_SEED;
    end else if (en) begin
      lfsr_state <= (lfsr_state >> 1) ^ (lfsr_state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/replay_batch_scheduler.sv
// Replay-memory write pointer / fill tracking plus a random-index batch reader.
module replay_batch_scheduler
  import replay_batch_scheduler_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH = 10000,
  parameter int unsigned MIN_FILL     = 1000,
  parameter int unsigned BATCH_SIZE   = 32,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEMORY_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic                          i_batch_req,
  output logic                          o_mem_valid,
  output logic                          o_mem_rw_select,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  input  logic                          i_mem_rd_valid,
  output logic                          o_sample_valid,
  output logic [$clog2(BATCH_SIZE)-1:0] o_sample_index,
  output logic                          o_batch_done,
  output logic                          o_batch_reject,
  output logic                          o_ready_for_train,
  output logic                          o_busy,
  output logic [ADDR_WIDTH:0]           o_fill_count
);

  localparam int unsigned IDX_WIDTH  = $clog2(BATCH_SIZE);
  localparam int unsigned FILL_WIDTH = ADDR_WIDTH + 1;

  state_e                  state;
  state_e                  state_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [FILL_WIDTH-1:0]   fill_count;
  logic [IDX_WIDTH-1:0]    sample_cnt;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    batch_done_q;
  logic                    batch_reject_q;
  logic [LFSR_WIDTH-1:0]   lfsr_state;
  logic [ADDR_WIDTH-1:0]   candidate;
  logic                    cand_hit;
  logic                    last_sample;
  logic                    wr_accept;
  logic                    unused_lfsr_bits;

  lfsr_galois_23 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .en         (state == ST_SAMPLE),
    .lfsr_state (lfsr_state)
  );

  assign candidate         = lfsr_state[ADDR_WIDTH-1:0];
  assign unused_lfsr_bits  = ^lfsr_state[LFSR_WIDTH-1:ADDR_WIDTH];
  assign cand_hit          = FILL_WIDTH'(candidate) < fill_count;
  assign last_sample       = sample_cnt == IDX_WIDTH'(BATCH_SIZE - 1);
  assign o_ready_for_train = fill_count >= FILL_WIDTH'(MIN_FILL);
  assign o_fill_count      = fill_count;
  assign o_batch_done      = batch_done_q;
  assign o_batch_reject    = batch_reject_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (i_batch_req && o_ready_for_train) state_next = ST_SAMPLE;
      ST_SAMPLE: if (cand_hit) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT:   if (i_mem_rd_valid) state_next = last_sample ? ST_DONE : ST_SAMPLE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory command and sample outputs; the read slot in ISSUE blocks writes
  always_comb begin
    o_wr_ready      = 1'b1;
    o_mem_valid     = 1'b0;
    o_mem_rw_select = RW_WRITE;
    o_mem_addr      = '0;
    o_sample_valid  = 1'b0;
    o_sample_index  = sample_cnt;
    o_busy          = 1'b1;
    case (state)
      ST_IDLE:  o_busy = 1'b0;
      ST_ISSUE: begin
        o_wr_ready      = 1'b0;
        o_mem_valid     = 1'b1;
        o_mem_rw_select = RW_READ;
        o_mem_addr      = rd_addr;
      end
      ST_WAIT:  o_sample_valid = i_mem_rd_valid;
      default:  ;
    endcase
    wr_accept = i_wr_valid && o_wr_ready;
    if (wr_accept) begin
      o_mem_valid     = 1'b1;
      o_mem_rw_select = RW_WRITE;
      o_mem_addr      = wr_ptr;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      fill_count     <= '0;
      sample_cnt     <= '0;
      rd_addr        <= '0;
      batch_done_q   <= 1'b0;
      batch_reject_q <= 1'b0;
    end else begin
      batch_done_q   <= (state == ST_WAIT) && (state_next == ST_DONE);
      batch_reject_q <= (state == ST_IDLE) && i_batch_req && !o_ready_for_train;

      if (wr_accept) begin
        wr_ptr <= (wr_ptr == ADDR_WIDTH'(MEMORY_WIDTH - 1)) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        if (fill_count != FILL_WIDTH'(MEMORY_WIDTH)) begin
          fill_count <= fill_count + FILL_WIDTH'(1);
        end
      end

      if ((state == ST_IDLE) && i_batch_req && o_ready_for_train) begin
        sample_cnt <= '0;
      end else if ((state == ST_WAIT) && i_mem_rd_valid) begin
        sample_cnt <= sample_cnt + IDX_WIDTH'(1);
      end

      if ((state == ST_SAMPLE) && cand_hit) begin
        rd_addr <= candidate;
      end
    end
  end

endmodule

// File: tb/tb_replay_batch_scheduler.sv
// Scoreboard bench: random writes/batches against a fill/pointer/batch reference model.
module tb_replay_batch_scheduler;

  localparam int unsigned MW = 16;
  localparam int unsigned MF = 4;
  localparam int unsigned BS = 3;
  localparam int unsigned AW = $clog2(MW);
  localparam int unsigned IW = $clog2(BS);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic          i_batch_req;
  logic          o_mem_valid;
  logic          o_mem_rw_select;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_rd_valid;
  logic          o_sample_valid;
  logic [IW-1:0] o_sample_index;
  logic          o_batch_done;
  logic          o_batch_reject;
  logic          o_ready_for_train;
  logic          o_busy;
  logic [AW:0]   o_fill_count;

  replay_batch_scheduler #(
    .MEMORY_WIDTH (MW),
    .MIN_FILL     (MF),
    .BATCH_SIZE   (BS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_wr_valid        (i_wr_valid),
    .o_wr_ready        (o_wr_ready),
    .i_batch_req       (i_batch_req),
    .o_mem_valid       (o_mem_valid),
    .o_mem_rw_select   (o_mem_rw_select),
    .o_mem_addr        (o_mem_addr),
    .i_mem_rd_valid    (i_mem_rd_valid),
    .o_sample_valid    (o_sample_valid),
    .o_sample_index    (o_sample_index),
    .o_batch_done      (o_batch_done),
    .o_batch_reject    (o_batch_reject),
    .o_ready_for_train (o_ready_for_train),
    .o_busy            (o_busy),
    .o_fill_count      (o_fill_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (values the DUT should show in the current cycle)
  int m_ptr, m_fill, m_samp, reads, outstanding;
  int reads_total = 0;
  bit exp_busy, exp_rej, exp_done;
  int exp_q[$];          // 0 = expect reject, 1 = expect completed batch
  int rd_timer = -1;
  bit stray = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: returns read data 1..3 cycles after the command, plus optional stray pulses
  always @(posedge clk) begin
    #2;
    i_mem_rd_valid = stray;
    if (rd_timer > 0) begin
      rd_timer--;
      if (rd_timer == 0) begin
        i_mem_rd_valid = 1'b1;
        rd_timer = -1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    bit rd_cmd, wr_acc, busy_n, rej_n, done_n;
    int k;
    if (rst) begin
      m_ptr = 0; m_fill = 0; m_samp = 0; reads = 0; outstanding = 0;
      exp_busy = 0; exp_rej = 0; exp_done = 0;
      exp_q.delete();
      rd_timer = -1;
    end else begin
      busy_n = exp_busy; rej_n = 0; done_n = 0;
      rd_cmd = o_mem_valid && o_mem_rw_select;

      chk("busy", int'(o_busy), int'(exp_busy));
      chk("fill_count", int'(o_fill_count), m_fill);
      chk("ready_for_train", int'(o_ready_for_train), int'(m_fill >= int'(MF)));
      chk("wr_ready", int'(o_wr_ready), int'(!rd_cmd));

      chk("batch_reject", int'(o_batch_reject), int'(exp_rej));
      if (o_batch_reject && exp_q.size() > 0) begin
        k = exp_q.pop_front();
        chk("reject_kind", k, 0);
      end

      chk("batch_done", int'(o_batch_done), int'(exp_done));
      if (o_batch_done && exp_q.size() > 0) begin
        k = exp_q.pop_front();
        chk("done_kind", k, 1);
        chk("reads_per_batch", reads, int'(BS));
        busy_n = 0;
      end

      chk("sample_valid", int'(o_sample_valid), int'(i_mem_rd_valid && outstanding > 0));
      if (o_sample_valid) begin
        chk("sample_index", int'(o_sample_index), m_samp);
        m_samp++;
        outstanding--;
        if (m_samp == int'(BS)) done_n = 1;
      end

      wr_acc = i_wr_valid && o_wr_ready;
      if (rd_cmd) begin
        chk("read_in_batch", int'(exp_busy && outstanding == 0), 1);
        chk("read_addr_lt_fill", int'(int'(o_mem_addr) < m_fill), 1);
        reads++;
        reads_total++;
        outstanding++;
        rd_timer = int'($urandom_range(1, 3));
      end else if (wr_acc) begin
        chk("write_cmd", int'(o_mem_valid && !o_mem_rw_select), 1);
        chk("write_addr", int'(o_mem_addr), m_ptr);
      end else begin
        chk("mem_idle", int'(o_mem_valid), 0);
      end

      if (i_batch_req && !exp_busy) begin
        if (m_fill >= int'(MF)) begin
          exp_q.push_back(1);
          busy_n = 1; m_samp = 0; reads = 0;
        end else begin
          exp_q.push_back(0);
          rej_n = 1;
        end
      end

      if (wr_acc) begin
        m_ptr = (m_ptr + 1) % int'(MW);
        if (m_fill < int'(MW)) m_fill++;
      end

      exp_busy = busy_n;
      exp_rej  = rej_n;
      exp_done = done_n;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_n(input int n);
    i_wr_valid = 1'b1;
    repeat (n) tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic request();
    i_batch_req = 1'b1;
    tick();
    i_batch_req = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input bit rnd);
    int n = 0;
    while ((exp_busy || exp_q.size() != 0) && n < budget) begin
      if (rnd) begin
        i_wr_valid  = 1'($urandom_range(0, 1));
        i_batch_req = exp_busy && ($urandom_range(0, 7) == 0);
      end
      tick();
      n++;
    end
    if (rnd) begin
      i_wr_valid  = 1'b0;
      i_batch_req = 1'b0;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL batch_timeout: still pending after %0d cycles", budget);
    end
    tick();
  endtask

  initial begin
    int r0;
    int n;
    rst = 1'b1;
    i_wr_valid = 1'b0;
    i_batch_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_fill", int'(o_fill_count), 0);
    chk("reset_busy", int'(o_busy), 0);

    // Too few entries: request refused, stray read data ignored
    write_n(3);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    request();
    wait_quiet(50, 1'b0);

    // Pointer wrap and fill saturation
    do_reset();
    write_n(20);
    chk("fill_saturated", int'(o_fill_count), int'(MW));

    // Minimal fill, single batch
    do_reset();
    write_n(4);
    request();
    wait_quiet(2000, 1'b0);

    // Writes held high across a batch
    i_wr_valid = 1'b1;
    request();
    wait_quiet(2000, 1'b0);
    i_wr_valid = 1'b0;

    // Fill of five: reads only below the fill level
    do_reset();
    write_n(5);
    request();
    wait_quiet(2000, 1'b0);

    // Random traffic with concurrent writes and ignored requests
    do_reset();
    write_n(int'($urandom_range(4, 8)));
    for (int b = 0; b < 6; b++) begin
      request();
      wait_quiet(2000, 1'b1);
    end

    // Reset while waiting for read data
    do_reset();
    write_n(4);
    r0 = reads_total;
    request();
    n = 0;
    while (reads_total == r0 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL read_issue_timeout: no read after %0d cycles", n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fill_after_midbatch_rst", int'(o_fill_count), 0);
    chk("busy_after_midbatch_rst", int'(o_busy), 0);
    repeat (4) tick();
    request();
    wait_quiet(50, 1'b0);

    repeat (3) tick();
    chk("queue_drained", int'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
